// File: rtl/wave_display_render_pkg.sv
// rtl/wave_display_render_pkg.sv - shared types and constants for the waveform display renderer
// Purpose: display state encoding, draw-window geometry and the sample-to-row mapping.
// Contents: disp_state_t, X_WIN_BASE, Y_WIN_ROWS, SAMPLES_PER_BUF, SAMPLE_W, trace_row().
package wave_display_render_pkg;

    typedef enum logic {
        DRAW = 1'b0,
        IDLE = 1'b1
    } disp_state_t;

    localparam logic [10:0] X_WIN_BASE      = 11'd512;
    localparam logic [9:0]  Y_WIN_ROWS      = 10'd512;
    localparam int          SAMPLES_PER_BUF = 256;
    localparam int          SAMPLE_W        = $clog2(SAMPLES_PER_BUF);

    // Larger sample values plot higher on screen, so the row index is inverted.
    function automatic logic [7:0] trace_row(input logic [7:0] sample);
        return 8'd255 - sample;
    endfunction

endpackage

// File: rtl/dffr.sv
// rtl/dffr.sv - resettable register
// Purpose: WIDTH-bit flop, synchronous active-high reset to zero.
// Ports: clk, reset, d (next value), q (registered value).
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dffre.sv
// rtl/dffre.sv - resettable register with load enable
// Purpose: WIDTH-bit flop, synchronous active-high reset to zero, loads d when en is high.
// Ports: clk, reset, en (load enable), d (next value), q (registered value).
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wave_display_render_hit_test.sv
// rtl/wave_display_render_hit_test.sv - inclusive between test of a pixel row against two trace rows
// Purpose: combinational check that ry lies between t_a and t_b inclusive, in either order,
//          which fills vertical gaps between neighbouring samples.
// Ports: ry (pixel row level), t_a / t_b (trace rows of previous / current sample), hit.
module wave_hit_test (
    input  logic [7:0] ry,
    input  logic [7:0] t_a,
    input  logic [7:0] t_b,
    output logic       hit
);

    logic [7:0] lo;
    logic [7:0] hi;

    assign lo  = (t_a < t_b) ? t_a : t_b;
    assign hi  = (t_a < t_b) ? t_b : t_a;
    assign hit = (ry >= lo) && (ry <= hi);

endmodule

// File: rtl/wave_display_render.sv
// rtl/wave_display_render.sv - renders the captured waveform into the VGA draw window
// Purpose: reads the display-owned half of the sample RAM per pixel, decides trace hits and
//          emits registered rgb two clocks after the coordinate. wave_display_idle tells the
//          capture stage when it may swap buffers.
// Optional: define WAVE_DISPLAY_MIDLINE_EN to draw a centre line in MID_RGB under the trace.
// Ports: clk, reset (sync, active-high), valid/x/y (VGA coordinate), read_index (RAM half),
//        read_value (RAM data, one clock after read_address), read_address,
//        valid_pixel, r, g, b, wave_display_idle.
module wave_display_render
    import wave_display_render_pkg::*;
#(
    parameter logic [23:0] WAVE_RGB = 24'hFFFFFF,
    parameter logic [23:0] MID_RGB  = 24'h00FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    // Stage 0: address the RAM directly from the incoming coordinate.
    assign read_address = {read_index, x[SAMPLE_W:1]};

    logic in_window;
    assign in_window = (x[10:9] == X_WIN_BASE[10:9]) && (y < Y_WIN_ROWS);

    // Stage 1: coordinate attributes aligned with the RAM data that returns this cycle.
    logic [11:0] s1_d;
    logic [11:0] s1_q;
    logic        s1_valid;
    logic        s1_in_win;
    logic        s1_new;
    logic        s1_first;
    logic [7:0]  s1_ry;

    assign s1_d = {valid, in_window, in_window && !x[0], x[SAMPLE_W:1] == '0, y[8:1]};

    dffr #(.WIDTH(12)) u_s1 (.clk(clk), .reset(reset), .d(s1_d), .q(s1_q));

    assign {s1_valid, s1_in_win, s1_new, s1_first, s1_ry} = s1_q;

    // Sample history. The even column of a sample uses the freshly returned value, so the
    // hit test works on the values the registers are about to take, not their old contents.
    logic [7:0] prev_q;
    logic [7:0] cur_q;
    logic [7:0] eff_prev;
    logic [7:0] eff_cur;

    assign eff_cur  = s1_new ? read_value : cur_q;
    assign eff_prev = s1_new ? (s1_first ? read_value : cur_q) : prev_q;

    dffre #(.WIDTH(16)) u_hist (
        .clk(clk), .reset(reset), .en(s1_new),
        .d({eff_prev, eff_cur}), .q({prev_q, cur_q})
    );

    logic in_range;
    logic hit;

    wave_hit_test u_hit (
        .ry(s1_ry), .t_a(trace_row(eff_prev)), .t_b(trace_row(eff_cur)), .hit(in_range)
    );

    assign hit = s1_valid && s1_in_win && in_range;

    // Stage 2: registered pixel outputs.
    logic        vp_d;
    logic [23:0] rgb_d;

`ifdef WAVE_DISPLAY_MIDLINE_EN
    logic mid;
    assign mid   = s1_valid && s1_in_win && (s1_ry == 8'd127);
    assign vp_d  = hit || mid;
    assign rgb_d = hit ? WAVE_RGB : (mid ? MID_RGB : 24'h0);
`else
    assign vp_d  = hit;
    assign rgb_d = hit ? WAVE_RGB : 24'h0;
`endif

    dffr #(.WIDTH(25)) u_out (
        .clk(clk), .reset(reset), .d({vp_d, rgb_d}), .q({valid_pixel, r, g, b})
    );

    // Idle while the beam is below the window; blanking cycles never move the state.
    disp_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DRAW;
        end else if (valid) begin
            case (state)
                DRAW: if (y >= Y_WIN_ROWS) state <= IDLE;
                IDLE: if (y <  Y_WIN_ROWS) state <= DRAW;
                default: state <= DRAW;
            endcase
        end
    end

    assign wave_display_idle = (state == IDLE);

endmodule

// File: tb/tb_wave_display_render.sv
// tb/tb_wave_display_render.sv - scoreboard bench for wave_display_render
module tb_wave_display_render;

    localparam logic [23:0] WAVE = 24'hFFFFFF;
    localparam logic [23:0] MID  = 24'h00FF00;
`ifdef WAVE_DISPLAY_MIDLINE_EN
    localparam bit MIDLINE = 1'b1;
`else
    localparam bit MIDLINE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [10:0] x;
    logic [9:0]  y;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;

    wave_display_render #(.WAVE_RGB(WAVE), .MID_RGB(MID)) dut (
        .clk(clk), .reset(reset), .valid(valid), .x(x), .y(y),
        .read_index(read_index), .read_value(read_value), .read_address(read_address),
        .valid_pixel(valid_pixel), .r(r), .g(g), .b(b),
        .wave_display_idle(wave_display_idle)
    );

    always #5 clk = ~clk;

    // Sample RAM: data appears one clock after the address.
    logic [7:0] ram [0:511];
    always @(posedge clk) read_value <= ram[read_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int issue; logic vp; logic [23:0] rgb; } pix_t;
    typedef struct { int issue; logic idle; } idle_t;
    pix_t  pq[$];
    idle_t iq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state: last two samples loaded and whether the beam is below the window.
    int m_cur  = 0;
    int m_prev = 0;
    bit m_idle = 0;

    task automatic drive(input bit v, input int xi, input int yi, input bit ri);
        bit   in_win;
        int   s, val, ry, tp, tc, lo, hi;
        bit   hit, mid;
        pix_t pe;
        idle_t ie;
        @(negedge clk);
        reset = 1'b0; valid = v; x = xi[10:0]; y = yi[9:0]; read_index = ri;
        in_win = (xi >= 512) && (xi < 1024) && (yi < 512);
        if (in_win && (xi % 2 == 0)) begin
            s   = (xi - 512) / 2;
            val = ram[ri * 256 + s];
            m_prev = (s == 0) ? val : m_cur;
            m_cur  = val;
        end
        ry = (yi % 512) / 2;
        tp = 255 - m_prev;
        tc = 255 - m_cur;
        lo = (tp < tc) ? tp : tc;
        hi = (tp < tc) ? tc : tp;
        hit = v && in_win && (ry >= lo) && (ry <= hi);
        mid = MIDLINE && v && in_win && (ry == 127);
        pe.issue = cyc;
        pe.vp    = hit || mid;
        pe.rgb   = hit ? WAVE : (mid ? MID : 24'h0);
        pq.push_back(pe);
        if (v) m_idle = (yi >= 512);
        ie.issue = cyc;
        ie.idle  = m_idle;
        iq.push_back(ie);
        #1;
        check("read_address", {23'd0, read_address}, ri * 256 + ((xi % 512) / 2));
    endtask

    task automatic blank(input int n, input int yi, input bit ri);
        for (int i = 0; i < n; i++) drive(1'b0, 1100, yi, ri);
    endtask

    task automatic scan_row(input int yi, input int x0, input int x1, input bit ri);
        for (int xi = x0; xi <= x1; xi++) drive(1'b1, xi, yi, ri);
        blank(2, yi, ri);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1; valid = 1'b1; x = 11'd600; y = 10'd200; read_index = 1'b0;
        end
        m_cur = 0; m_prev = 0; m_idle = 0;
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    int last_rst = -10;
    initial begin
        pix_t  pe;
        idle_t ie;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pq.delete();
                iq.delete();
                last_rst = cyc;
                check("reset_outputs", {7'd0, valid_pixel, r, g, b}, 32'd0);
                check("reset_idle", {31'd0, wave_display_idle}, 32'd0);
            end else begin
                if (cyc == last_rst + 1)
                    check("post_reset_vp", {31'd0, valid_pixel}, 32'd0);
                while (pq.size() > 0 && pq[0].issue + 2 == cyc) begin
                    pe = pq.pop_front();
                    check("valid_pixel", {31'd0, valid_pixel}, {31'd0, pe.vp});
                    check("rgb", {8'd0, r, g, b}, {8'd0, pe.rgb});
                end
                while (iq.size() > 0 && iq[0].issue + 1 == cyc) begin
                    ie = iq.pop_front();
                    check("idle", {31'd0, wave_display_idle}, {31'd0, ie.idle});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int xi;
        reset = 1'b1; valid = 1'b0; x = '0; y = '0; read_index = 1'b0;
        for (int i = 0; i < 512; i++) ram[i] = 8'd0;
        do_reset(3);

        // Flat 128 in half 0: only ry 127 lights.
        for (int i = 0; i < 256; i++) ram[i] = 8'd128;
        foreach (ram[i]) if (i >= 256) ram[i] = 8'($urandom_range(0, 255));
        scan_row(0, 508, 1027, 1'b0);
        scan_row(253, 508, 1027, 1'b0);
        scan_row(254, 508, 1027, 1'b0);
        scan_row(255, 508, 1027, 1'b0);
        scan_row(256, 508, 1027, 1'b0);
        scan_row(600, 508, 1027, 1'b0);

        // Step between samples 10 and 11 fills the whole column.
        for (int i = 0; i < 256; i++) ram[i] = 8'd0;
        ram[11] = 8'd255;
        scan_row(0, 512, 1023, 1'b0);
        scan_row(77, 512, 1023, 1'b0);
        scan_row(255, 512, 1023, 1'b0);
        scan_row(510, 512, 1023, 1'b0);
        scan_row(511, 512, 1023, 1'b0);

        // Single hit coordinate then the same coordinate with valid low.
        ram[44] = 8'd250;
        drive(1'b1, 600, 10, 1'b0);
        drive(1'b0, 600, 10, 1'b0);
        blank(3, 10, 1'b0);

        // Idle tracking across the bottom of the window, blanking and wrap.
        scan_row(511, 512, 520, 1'b0);
        scan_row(512, 0, 10, 1'b0);
        scan_row(1023, 0, 10, 1'b0);
        blank(4, 1023, 1'b0);
        scan_row(0, 0, 10, 1'b0);
        blank(3, 0, 1'b0);

        // Ramp in half 1 gives a diagonal trace.
        for (int i = 0; i < 256; i++) ram[256 + i] = 8'(i);
        scan_row(0, 512, 1023, 1'b1);
        scan_row(128, 512, 1023, 1'b1);
        scan_row(300, 512, 1023, 1'b1);
        scan_row(511, 512, 1023, 1'b1);

        // Randomized rows with gaps in valid and occasional column jumps.
        for (int i = 0; i < 512; i++) ram[i] = 8'($urandom_range(0, 255));
        for (int row = 0; row < 16; row++) begin
            int  yi;
            bit  ri;
            yi = (row % 4 == 3) ? $urandom_range(512, 1023) : $urandom_range(0, 511);
            ri = 1'($urandom_range(0, 1));
            xi = $urandom_range(500, 520);
            while (xi < 1040) begin
                drive($urandom_range(0, 7) != 0, xi, yi, ri);
                xi = ($urandom_range(0, 31) == 0) ? xi + $urandom_range(2, 40) : xi + 1;
            end
            blank($urandom_range(1, 4), yi, ri);
        end

        // Reset mid-scan, then resume.
        for (int i = 0; i < 256; i++) ram[i] = 8'd128;
        scan_row(200, 512, 700, 1'b0);
        for (int xi2 = 512; xi2 < 560; xi2++) drive(1'b1, xi2, 200, 1'b0);
        do_reset(2);
        scan_row(254, 512, 1023, 1'b0);

`ifdef WAVE_DISPLAY_MIDLINE_EN
        // Flat zero buffer: the midline shows where the trace is absent.
        for (int i = 0; i < 256; i++) ram[i] = 8'd0;
        scan_row(253, 512, 1023, 1'b0);
        scan_row(254, 512, 1023, 1'b0);
        scan_row(255, 512, 1023, 1'b0);
`endif

        blank(4, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", pq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wave_display_render.md
Name: wave_display_render

Overview:
- Downstream consumer of the double-buffered sample RAM written by the capture stage.
- For each VGA pixel coordinate it reads the half selected by read_index and decides whether the pixel lies on the waveform trace. It then emits registered RGB and valid_pixel to the VGA output mux.
- It produces wave_display_idle, which gates the capture stage's buffer swap so the displayed half never changes mid-draw.

Parameters:
- WAVE_RGB, 24'hFFFFFF, trace colour as {r,g,b}.
- MID_RGB, 24'h00FF00, centre-line colour; used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- valid  input  1  VGA coordinate is inside the visible area this cycle
- x  input  11  VGA column, 0..1279
- y  input  10  VGA row, 0..1023
- read_index  input  1  RAM half currently owned by the display
- read_value  input  8  RAM data; valid one cycle after read_address
- read_address  output  9  {read_index, x[8:1]}, combinational from inputs
- valid_pixel  output  1  r/g/b carry trace colour this cycle
- r  output  8  red
- g  output  8  green
- b  output  8  blue
- wave_display_idle  output  1  high while no rows of the draw window are being scanned

Behaviour:
- Draw window: x in 512..1023 (x[10:9]==2'b01) and y in 0..511 (y[9]==0).
- Each sample is 2 columns wide, giving 256 samples per window.
- Pipeline:
  - Stage 0 (combinational): read_address = {read_index, x[8:1]}.
  - Stage 1 (registered): valid, x, y, in_window and a new_sample flag are registered; new_sample = in_window && x[0]==0.
  - Stage 2 (registered outputs): evaluate and register outputs.
  - Latency from a coordinate to its valid_pixel/rgb is exactly 2 clocks.
- Sample tracking, at stage 1 when new_sample:
  - cur <= read_value and prev <= cur.
  - If x[8:1]==0 (first sample of the row), prev <= read_value, so the first column draws a single point.
- Scaling: trace row t = 8'd255 - sample, so larger values plot higher on screen. The pixel row uses ry = y[8:1] (2 rows per level).
- Hit test: hit = stage-1 valid && in_window && ry lies between t(prev) and t(cur), inclusive, in either order.
  - This fills vertical gaps, so the trace is continuous.
  - Widths: compare 8-bit unsigned values; no arithmetic overflow is possible.
- Outputs:
  - valid_pixel <= hit; {r,g,b} <= hit ? WAVE_RGB : 24'h0.
  - Outside the window or with valid low: valid_pixel=0, rgb=0.
- FSM, state register wave_display_idle; state is updated only on cycles with valid=1:
  - DRAW (idle=0): valid && y[9]==1 -> IDLE.
  - IDLE (idle=1): valid && y[9]==0 -> DRAW.
  - Blanking (valid=0) holds the current state.
- Reset: state=DRAW, wave_display_idle=0, valid_pixel=0, r=g=b=0, prev=cur=0, pipeline valid=0.
  - Reset mid-frame discards the pipeline. The first two post-reset clocks output valid_pixel=0.
- read_index change: sampled combinationally each cycle. The capture stage changes it only while idle=1, so no glitch occurs within the draw window; no internal latching.
- x leaving the window mid-row: no new_sample, and hit is forced to 0. prev/cur are stale but are reloaded at the next row's x[8:1]==0.

Optional Feature:
- Macro WAVE_DISPLAY_MIDLINE_EN.
- When defined: inside the window with valid, pixels with ry==8'd127 (value 128) and no trace hit give valid_pixel=1, rgb=MID_RGB. A trace hit takes priority over the midline. Latency is unchanged.
- When undefined: no midline logic; MID_RGB is unused.

Decomposition:
- Shared package holds:
  - state encodings DRAW=1'b0, IDLE=1'b1;
  - window constants X_WIN_BASE=11'd512 and Y_WIN_ROWS=10'd512;
  - SAMPLES_PER_BUF=256.
- Registers use the existing dffr/dffre flops.
- One natural sub-module: wave_hit_test, the combinational between-inclusive compare of ry against t(prev) and t(cur).

Test Plan:
- RAM half 0 = constant 128, read_index=0, full frame scan -> valid_pixel only at ry==127 (y=254,255) for x 512..1023, 2-cycle delay; zero elsewhere.
- Step: sample[10]=0, sample[11]=255 -> at x=534/535 the pixels for y=0..511 are all lit (vertical fill); x=532 lights only y=510,511.
- Coordinate (600,10) at cycle n with hit -> valid_pixel=1 and rgb=WAVE_RGB at cycle n+2, not before; valid=0 -> outputs 0.
- Scan y 511->512->1023 then wrap to 0 -> idle rises one clock after y=512 is accepted, falls one clock after y=0 with valid; blanking holds it.
- read_index=1 with half 1 = ramp (value = address) -> read_address = 9'h100 + x[8:1]; trace is a diagonal from bottom-left to top-right.
- Reset asserted at y=200 mid-scan -> next clock all outputs 0 and idle=0; valid_pixel stays 0 for 2 clocks after release. With WAVE_DISPLAY_MIDLINE_EN on a flat 0 buffer -> the midline is lit at y=254,255 in MID_RGB.
